// File: rtl/cpu_memory.sv
// rtl/cpu_memory.sv - moxie memory-access stage driving a big-endian Wishbone-style data bus
// Optional bus-cycle timeout enabled by defining CPU_MEMORY_BUS_TIMEOUT_EN.
module cpu_memory #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        register_write_index_i,
  input  logic              register_write_enable_i,
  input  logic              memory_write_enable_i,
  input  logic              memory_read_enable_i,
  input  logic [1:0]        memory_size_i,
  input  logic [ADDR_W-1:0] memory_address_i,
  input  logic [31:0]       result_i,
  output logic [3:0]        register_write_index_o,
  output logic              register_write_enable_o,
  output logic [31:0]       result_o,
  output logic              stall_o,
  output logic              bus_error_o,
  output logic [ADDR_W-1:0] dwb_adr_o,
  output logic [31:0]       dwb_dat_o,
  input  logic [31:0]       dwb_dat_i,
  output logic [3:0]        dwb_sel_o,
  output logic              dwb_we_o,
  output logic              dwb_cyc_o,
  output logic              dwb_stb_o,
  input  logic              dwb_ack_i
);

  typedef enum logic {IDLE, BUS} state_t;

  state_t      state, state_next;
  logic        req, ack, timeout;
  logic [1:0]  size_q, off_q;
  logic [3:0]  idx_q;
  logic [3:0]  sel_next;
  logic [31:0] dat_next;
  logic [31:0] load_data;

  assign req = memory_read_enable_i | memory_write_enable_i;
  assign ack = (state == BUS) & dwb_ack_i;

`ifdef CPU_MEMORY_BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt;
  logic             bus_error_q;

  // Counter holds zero in IDLE, so every BUS entry starts from a clean count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)              cnt <= '0;
    else if (state == IDLE) cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

  assign timeout     = (state == BUS) & ~dwb_ack_i & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_error_o = bus_error_q;
`else
  assign timeout     = (TIMEOUT_CYCLES < 0);
  assign bus_error_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall_o    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_next = BUS;
          stall_o    = 1'b1;
        end
      end
      BUS: begin
        if (ack || timeout) state_next = IDLE;
        else                stall_o    = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    if (rst_i) stall_o = 1'b0;
  end

  // Big-endian lanes: byte offset 0 lives in dat[31:24] (sel bit 3).
  always_comb begin
    sel_next = 4'b1111;
    dat_next = result_i;
    case (memory_size_i)
      2'b01: begin
        sel_next = memory_address_i[1] ? 4'b0011 : 4'b1100;
        dat_next = {2{result_i[15:0]}};
      end
      2'b10: begin
        sel_next = 4'b1000 >> memory_address_i[1:0];
        dat_next = {4{result_i[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_data = dwb_dat_i;
    case (size_q)
      2'b01:   load_data = {16'h0, off_q[1] ? dwb_dat_i[15:0] : dwb_dat_i[31:16]};
      2'b10:   load_data = {24'h0, dwb_dat_i[(3 - off_q) * 8 +: 8]};
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      register_write_index_o  <= '0;
      register_write_enable_o <= 1'b0;
      result_o                <= '0;
      dwb_adr_o               <= '0;
      dwb_dat_o               <= '0;
      dwb_sel_o               <= '0;
      dwb_we_o                <= 1'b0;
      dwb_cyc_o               <= 1'b0;
      dwb_stb_o               <= 1'b0;
      size_q                  <= '0;
      off_q                   <= '0;
      idx_q                   <= '0;
`ifdef CPU_MEMORY_BUS_TIMEOUT_EN
      bus_error_q             <= 1'b0;
`endif
    end else begin
`ifdef CPU_MEMORY_BUS_TIMEOUT_EN
      bus_error_q <= timeout;
`endif
      case (state)
        IDLE: begin
          if (req) begin
            register_write_enable_o <= 1'b0;
            dwb_cyc_o <= 1'b1;
            dwb_stb_o <= 1'b1;
            dwb_we_o  <= memory_write_enable_i;
            dwb_adr_o <= {memory_address_i[ADDR_W-1:2], 2'b00};
            dwb_sel_o <= sel_next;
            dwb_dat_o <= dat_next;
            size_q    <= memory_size_i;
            off_q     <= memory_address_i[1:0];
            idx_q     <= register_write_index_i;
          end else begin
            register_write_enable_o <= register_write_enable_i;
            register_write_index_o  <= register_write_index_i;
            result_o                <= result_i;
          end
        end
        BUS: begin
          register_write_enable_o <= 1'b0;
          if (ack) begin
            dwb_cyc_o <= 1'b0;
            dwb_stb_o <= 1'b0;
            if (!dwb_we_o) begin
              register_write_enable_o <= 1'b1;
              register_write_index_o  <= idx_q;
              result_o                <= load_data;
            end
          end else if (timeout) begin
            dwb_cyc_o <= 1'b0;
            dwb_stb_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_memory.sv
// tb/tb_cpu_memory.sv - directed table-driven bench for cpu_memory
module tb_cpu_memory;

`ifdef CPU_MEMORY_BUS_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk_i, rst_i;
  logic [3:0]  register_write_index_i, register_write_index_o;
  logic        register_write_enable_i, register_write_enable_o;
  logic        memory_write_enable_i, memory_read_enable_i;
  logic [1:0]  memory_size_i;
  logic [31:0] memory_address_i, result_i, result_o;
  logic        stall_o, bus_error_o;
  logic [31:0] dwb_adr_o, dwb_dat_o, dwb_dat_i;
  logic [3:0]  dwb_sel_o;
  logic        dwb_we_o, dwb_cyc_o, dwb_stb_o, dwb_ack_i;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_memory #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .register_write_index_i(register_write_index_i),
    .register_write_enable_i(register_write_enable_i),
    .memory_write_enable_i(memory_write_enable_i),
    .memory_read_enable_i(memory_read_enable_i),
    .memory_size_i(memory_size_i),
    .memory_address_i(memory_address_i),
    .result_i(result_i),
    .register_write_index_o(register_write_index_o),
    .register_write_enable_o(register_write_enable_o),
    .result_o(result_o),
    .stall_o(stall_o),
    .bus_error_o(bus_error_o),
    .dwb_adr_o(dwb_adr_o), .dwb_dat_o(dwb_dat_o), .dwb_dat_i(dwb_dat_i),
    .dwb_sel_o(dwb_sel_o), .dwb_we_o(dwb_we_o), .dwb_cyc_o(dwb_cyc_o),
    .dwb_stb_o(dwb_stb_o), .dwb_ack_i(dwb_ack_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rd, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [3:0]  idx;
    int          waits;
    logic [31:0] rdata;
    logic [31:0] exp_adr;
    logic [3:0]  exp_sel;
    logic        exp_we;
    logic [31:0] exp_dat, exp_result;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    memory_read_enable_i    = 1'b0;
    memory_write_enable_i   = 1'b0;
    register_write_enable_i = 1'b0;
    register_write_index_i  = 4'h0;
    memory_size_i           = 2'b00;
    memory_address_i        = 32'h0;
    result_i                = 32'h0;
  endtask

  // Request cycle, v.waits BUS cycles without ack, then the ack cycle.
  task automatic run_vec(input vec_t v, input string nm);
    int stall_cnt;
    memory_read_enable_i   = v.rd;
    memory_write_enable_i  = v.wr;
    memory_size_i          = v.size;
    memory_address_i       = v.addr;
    result_i               = v.wdata;
    register_write_index_i = v.idx;
    @(negedge clk_i);
    chk({nm, "_req_stall"}, 32'(stall_o), 32'd1);
    stall_cnt = stall_o ? 1 : 0;
    @(posedge clk_i); #1;
    idle_inputs();
    for (int k = 0; k < v.waits; k++) begin
      @(negedge clk_i);
      if (stall_o) stall_cnt++;
      chk({nm, "_cyc"}, {30'h0, dwb_cyc_o, dwb_stb_o}, 32'd3);
      if (k == 0) begin
        chk({nm, "_adr"}, dwb_adr_o, v.exp_adr);
        chk({nm, "_sel"}, 32'(dwb_sel_o), 32'(v.exp_sel));
        chk({nm, "_we"}, 32'(dwb_we_o), 32'(v.exp_we));
        chk({nm, "_rwe_bus"}, 32'(register_write_enable_o), 32'd0);
        if (v.exp_we) chk({nm, "_dat"}, dwb_dat_o, v.exp_dat);
      end
      @(posedge clk_i); #1;
    end
    dwb_ack_i = 1'b1;
    dwb_dat_i = v.rdata;
    @(negedge clk_i);
    chk({nm, "_ack_stall"}, 32'(stall_o), 32'd0);
    chk({nm, "_ack_adr"}, dwb_adr_o, v.exp_adr);
    chk({nm, "_stall_cycles"}, 32'(stall_cnt), 32'(v.waits + 1));
    @(posedge clk_i); #1;
    dwb_ack_i = 1'b0;
    dwb_dat_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    chk({nm, "_cyc_done"}, {30'h0, dwb_cyc_o, dwb_stb_o}, 32'd0);
    chk({nm, "_rwe"}, 32'(register_write_enable_o), 32'(!v.exp_we));
    if (!v.exp_we) begin
      chk({nm, "_result"}, result_o, v.exp_result);
      chk({nm, "_idx"}, 32'(register_write_index_o), 32'(v.idx));
    end
    chk({nm, "_bus_err"}, 32'(bus_error_o), 32'd0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    // rd wr size addr wdata idx waits rdata exp_adr sel we exp_dat exp_result
    vecs[0] = '{1'b1, 1'b0, 2'b00, 32'h1002, 32'h0,        4'd5, 3, 32'hCAFEBABE, 32'h1000, 4'b1111, 1'b0, 32'h0,        32'hCAFEBABE};
    vecs[1] = '{1'b1, 1'b0, 2'b10, 32'h2003, 32'h0,        4'd2, 1, 32'h11223344, 32'h2000, 4'b0001, 1'b0, 32'h0,        32'h00000044};
    vecs[2] = '{1'b1, 1'b0, 2'b01, 32'h2000, 32'h0,        4'd7, 2, 32'h11223344, 32'h2000, 4'b1100, 1'b0, 32'h0,        32'h00001122};
    vecs[3] = '{1'b0, 1'b1, 2'b10, 32'h3001, 32'h000000AB, 4'd1, 1, 32'h0,        32'h3000, 4'b0100, 1'b1, 32'hABABABAB, 32'h0};
    vecs[4] = '{1'b0, 1'b1, 2'b01, 32'h2002, 32'h0000BEEF, 4'd1, 2, 32'h0,        32'h2000, 4'b0011, 1'b1, 32'hBEEFBEEF, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 2'b01, 32'h2003, 32'h0,        4'd9, 1, 32'h11223344, 32'h2000, 4'b0011, 1'b0, 32'h0,        32'h00003344};
    vecs[6] = '{1'b1, 1'b0, 2'b11, 32'h4003, 32'h0,        4'd4, 1, 32'h89ABCDEF, 32'h4000, 4'b1111, 1'b0, 32'h0,        32'h89ABCDEF};
    vecs[7] = '{1'b1, 1'b1, 2'b00, 32'h5000, 32'hDEADBEEF, 4'd6, 2, 32'h0,        32'h5000, 4'b1111, 1'b1, 32'hDEADBEEF, 32'h0};

    rst_i = 1'b1;
    dwb_ack_i = 1'b0;
    dwb_dat_i = 32'h0;
    idle_inputs();
    #2;
    chk("reset_rwe", 32'(register_write_enable_o), 32'd0);
    chk("reset_result", result_o, 32'd0);
    chk("reset_bus", {dwb_adr_o[27:0], dwb_sel_o}, 32'd0);
    chk("reset_ctl", {27'h0, stall_o, bus_error_o, dwb_we_o, dwb_cyc_o, dwb_stb_o}, 32'd0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;

    // ack in IDLE is ignored
    dwb_ack_i = 1'b1;
    @(negedge clk_i);
    chk("idle_ack_stall", 32'(stall_o), 32'd0);
    @(posedge clk_i); #1;
    dwb_ack_i = 1'b0;
    @(negedge clk_i);
    chk("idle_ack_rwe", 32'(register_write_enable_o), 32'd0);

    // pass-through
    @(posedge clk_i); #1;
    register_write_enable_i = 1'b1;
    register_write_index_i  = 4'd3;
    result_i                = 32'h12345678;
    @(negedge clk_i);
    chk("pass_stall", 32'(stall_o), 32'd0);
    @(posedge clk_i); #1;
    idle_inputs();
    @(negedge clk_i);
    chk("pass_rwe", 32'(register_write_enable_o), 32'd1);
    chk("pass_idx", 32'(register_write_index_o), 32'd3);
    chk("pass_result", result_o, 32'h12345678);
    chk("pass_stall2", 32'(stall_o), 32'd0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("pass_rwe_clear", 32'(register_write_enable_o), 32'd0);
    @(posedge clk_i); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // back-to-back: second op issued immediately after the first completes
    run_vec(vecs[1], "b2b_a");
    run_vec(vecs[3], "b2b_b");

    // reset while a bus cycle is in flight
    memory_read_enable_i   = 1'b1;
    memory_address_i       = 32'h6000;
    register_write_index_i = 4'd8;
    @(posedge clk_i); #1;
    idle_inputs();
    @(negedge clk_i);
    chk("rst_mid_cyc_before", 32'(dwb_cyc_o), 32'd1);
    #1 rst_i = 1'b1;
    #1;
    chk("rst_mid_cycstb", {30'h0, dwb_cyc_o, dwb_stb_o}, 32'd0);
    chk("rst_mid_stall", 32'(stall_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    dwb_ack_i = 1'b1;
    dwb_dat_i = 32'h55555555;
    @(posedge clk_i); #1;
    dwb_ack_i = 1'b0;
    @(negedge clk_i);
    chk("rst_mid_late_ack_rwe", 32'(register_write_enable_o), 32'd0);
    chk("rst_mid_late_ack_cyc", 32'(dwb_cyc_o), 32'd0);
    @(posedge clk_i); #1;

`ifdef CPU_MEMORY_BUS_TIMEOUT_EN
    // load with no ack aborts after TO BUS cycles
    memory_read_enable_i   = 1'b1;
    memory_address_i       = 32'h7000;
    register_write_index_i = 4'd2;
    @(posedge clk_i); #1;
    idle_inputs();
    for (int k = 0; k < TO; k++) begin
      @(negedge clk_i);
      chk("to_cyc", 32'(dwb_cyc_o), 32'd1);
      chk("to_stall", 32'(stall_o), (k == TO - 1) ? 32'd0 : 32'd1);
      chk("to_err_early", 32'(bus_error_o), 32'd0);
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    chk("to_cyc_drop", {30'h0, dwb_cyc_o, dwb_stb_o}, 32'd0);
    chk("to_err_pulse", 32'(bus_error_o), 32'd1);
    chk("to_rwe", 32'(register_write_enable_o), 32'd0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("to_err_once", 32'(bus_error_o), 32'd0);
    @(posedge clk_i); #1;

    // ack on the exact timeout cycle completes normally
    run_vec('{1'b1, 1'b0, 2'b00, 32'h7004, 32'h0, 4'd11, TO - 1, 32'h0BADF00D,
              32'h7004, 4'b1111, 1'b0, 32'h0, 32'h0BADF00D}, "to_ack_tie");
    @(negedge clk_i);
    chk("to_ack_tie_no_err", 32'(bus_error_o), 32'd0);
    @(posedge clk_i); #1;
`else
    // without the timeout a long wait still completes
    run_vec('{1'b1, 1'b0, 2'b10, 32'h7001, 32'h0, 4'd12, 300, 32'hA1B2C3D4,
              32'h7000, 4'b0100, 1'b0, 32'h0, 32'h000000B2}, "long_wait");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/cpu_memory.md
Name: cpu_memory

Overview:
- Memory-access stage of the moxie pipeline, directly downstream of execute and upstream of register write-back.
- Takes execute's result, register-write controls and memory-access request. Performs loads and stores on a Wishbone-style 32-bit data bus.
- Passes non-memory results through with one cycle of latency.
- Stalls the upstream stages while a bus cycle is in flight.

Parameters:
- ADDR_W, 32, data-bus address width (low 2 bits are the byte offset).
- TIMEOUT_CYCLES, 255, bus-cycle abort threshold; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset: asynchronous, active-high.
- register_write_index_i  in  4  destination register from execute.
- register_write_enable_i  in  1  execute result to be written to the register file.
- memory_write_enable_i  in  1  store request.
- memory_read_enable_i  in  1  load request.
- memory_size_i  in  2  access size: 00=long, 01=short, 10=byte, 11=long.
- memory_address_i  in  ADDR_W  byte address for the access.
- result_i  in  32  ALU result, or store data (store data right-justified).
- register_write_index_o  out  4  destination register to write-back.
- register_write_enable_o  out  1  write-back strobe.
- result_o  out  32  write-back data.
- stall_o  out  1  hold the upstream stages.
- bus_error_o  out  1  one-cycle pulse on a bus timeout.
- dwb_adr_o  out  ADDR_W  word-aligned bus address.
- dwb_dat_o  out  32  bus write data.
- dwb_dat_i  in  32  bus read data.
- dwb_sel_o  out  4  byte lane selects.
- dwb_we_o  out  1  bus write.
- dwb_cyc_o  out  1  bus cycle active.
- dwb_stb_o  out  1  bus strobe.
- dwb_ack_i  in  1  bus acknowledge.

Behaviour:
- Reset: all outputs are 0 (register_write_enable_o, result_o, register_write_index_o, stall_o, bus_error_o, all dwb_* outputs); FSM goes to IDLE. Reset asserted mid-cycle drops cyc/stb immediately and discards the pending request.
- FSM states are IDLE and BUS.
- IDLE, no memory request: next clock registers register_write_enable_i, register_write_index_i and result_i to the outputs (1-cycle latency). stall_o=0.
- IDLE, memory_read_enable_i or memory_write_enable_i high:
  - stall_o=1 combinationally in the same cycle.
  - Next clock latches address, size, data, direction and destination index.
  - Same clock asserts dwb_cyc_o and dwb_stb_o, and the FSM goes to BUS.
  - register_write_enable_o=0.
  - If read and write are both high, the write wins and the read is dropped.
- BUS: stall_o=1 and cyc/stb/adr/sel/we/dat are held stable until dwb_ack_i. Upstream inputs are ignored while in BUS; the request is already latched.
- On the ack clock: cyc/stb drop and the FSM returns to IDLE. stall_o falls combinationally in the ack cycle, so upstream advances on the same edge.
  - Load: register_write_enable_o=1, index=latched destination, result_o=extracted data, all visible the cycle after ack.
  - Store: register_write_enable_o=0.
- An ack of 0 cycles is impossible (minimum 1 BUS cycle). dwb_ack_i is ignored in IDLE.
- Minimum load latency: request cycle, then 1 BUS cycle, then result registered. Back-to-back memory ops re-enter BUS on the clock after ack.
- Lanes are big-endian. Lane 3 = dat[31:24] = byte offset 0.
  - Long: sel=1111; addr[1:0] is forced to 0.
  - Short: offset 0 -> sel=1100, offset 2 -> sel=0011; addr[0] is ignored.
  - Byte: offset n -> sel = 1000>>n.
- dwb_adr_o = address with bits [1:0] cleared.
- Store data is replicated across lanes: byte -> {4{b}}, short -> {2{h}}.
- Loads zero-extend the selected lane(s) to 32 bits.

Optional Feature:
- Macro: CPU_MEMORY_BUS_TIMEOUT_EN.
- Defined: an 8+ bit counter runs in BUS (width sized for TIMEOUT_CYCLES). When it reaches TIMEOUT_CYCLES without an ack:
  - cyc/stb drop and the FSM returns to IDLE.
  - bus_error_o pulses for 1 cycle.
  - A load writes no register (register_write_enable_o=0).
  - The counter clears on entry to BUS.
  - If ack and timeout arrive in the same cycle, ack wins.
- Not defined: no counter; BUS waits indefinitely; bus_error_o is tied to 0.

Test Plan:
- Pass-through: register_write_enable_i=1, index=3, result_i=0x12345678, no memory request -> next cycle enable_o=1, index_o=3, result_o=0x12345678; stall_o never set.
- Long load: read, size=00, addr=0x1002, ack after 3 BUS cycles with dat_i=0xCAFEBABE, index=5:
  - adr_o=0x1000, sel=1111, we=0, stall_o high for 4 cycles.
  - Cycle after ack: result_o=0xCAFEBABE, index_o=5, enable_o=1.
- Byte/short loads: byte addr=0x2003 with dat_i=0x11223344 -> sel=0001, result_o=0x00000044. Short addr=0x2000 -> sel=1100, result_o=0x00001122.
- Store: write, size=10, addr=0x3001, result_i=0x000000AB -> sel=0100, dat_o=0xABABABAB, we=1; after ack register_write_enable_o=0, stall_o=0.
- Reset mid-cycle and conflict:
  - rst_i asserted while in BUS -> cyc/stb/stall_o go to 0 asynchronously; the later ack is ignored.
  - Read and write both high -> we=1 (the write is performed).
- Timeout (macro defined, TIMEOUT_CYCLES=4): load with no ack -> after 4 BUS cycles cyc=0, bus_error_o pulses once, no register write. Ack on the exact timeout cycle -> normal completion and no error pulse.
